dphy_delay_calib: RTL and testbench

Input-delay calibration controller for the D-PHY receiver. It sweeps a common IDELAY tap across all 32 settings and, for each data lane, finds the longest contiguous run of taps on which the byte aligner reports sync hits. It then programs each lane to the centre of its run. It sits beside the D-PHY slave, drives its `delay_act_i`/`lane_delay_i` inputs, and observes the per-lane aligned-byte valid strobes in the byte clock domain.

---
 rtl/dphy_calib_pkg.sv | 49 ++++
 rtl/dphy_eye_tracker.sv | 67 ++++++
 rtl/dphy_delay_calib.sv | 150 +++++++++++++++
 tb/tb_dphy_delay_calib.sv | 312 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dphy_calib_pkg.sv
// Shared types and constants for the D-PHY input-delay calibration controller.
package dphy_calib_pkg;

    localparam int unsigned TAP_W   = 5;
    localparam int unsigned TAP_MAX = 31;
    localparam int unsigned RUN_W   = 6;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_SETTLE,
        ST_OBSERVE,
        ST_EVAL,
        ST_APPLY,
        ST_DONE
    } calib_state_t;

    typedef struct packed {
        logic [TAP_W-1:0] cur_start;
        logic [RUN_W-1:0] cur_len;
        logic             run_open;
        logic [TAP_W-1:0] best_start;
        logic [RUN_W-1:0] best_len;
    } lane_eye_t;

    // Strictly-greater comparison keeps the earlier run on a tie.
    function automatic lane_eye_t close_run(input lane_eye_t e);
        lane_eye_t r;
        r = e;
        if (e.run_open && (e.cur_len > e.best_len)) begin
            r.best_start = e.cur_start;
            r.best_len   = e.cur_len;
        end
        r.run_open = 1'b0;
        return r;
    endfunction

    function automatic logic [TAP_W-1:0] centre_tap(input logic [TAP_W-1:0] start,
                                                    input logic [RUN_W-1:0] len);
        logic [RUN_W-1:0] half;
        logic [RUN_W:0]   sum;
        half = (len == '0) ? '0 : ((len - RUN_W'(1)) >> 1);
        sum  = {2'b00, start} + {1'b0, half};
        if (sum[RUN_W:TAP_W] != '0)
            return TAP_W'(TAP_MAX);
        return sum[TAP_W-1:0];
    endfunction

endpackage

// File: rtl/dphy_eye_tracker.sv
// Per-lane eye tracker: saturating sync-hit counter, pass decision, longest
// passing-run bookkeeping and centre-tap computation.
module dphy_eye_tracker
    import dphy_calib_pkg::*;
#(
    parameter int unsigned PASS_THRESH = 4
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             clear_i,
    input  logic             observe_i,
    input  logic             eval_i,
    input  logic             last_i,
    input  logic             sync_hit_i,
    input  logic [TAP_W-1:0] tap_i,
    output logic [TAP_W-1:0] centre_o,
    output logic [RUN_W-1:0] best_len_o
);

    localparam int unsigned CNT_W = (PASS_THRESH < 1) ? 1 : $clog2(PASS_THRESH + 1);
    localparam logic [CNT_W-1:0] THRESH_V = CNT_W'(PASS_THRESH);

    logic [CNT_W-1:0] hit_cnt;
    lane_eye_t        eye;
    lane_eye_t        eye_next;
    logic             pass;

    assign pass = (hit_cnt >= THRESH_V);

    always_comb begin
        eye_next = eye;
        if (pass) begin
            if (eye.run_open) begin
                eye_next.cur_len = eye.cur_len + 1'b1;
            end else begin
                eye_next.cur_start = tap_i;
                eye_next.cur_len   = RUN_W'(1);
                eye_next.run_open  = 1'b1;
            end
        end else begin
            eye_next = close_run(eye);
        end
        // A run still open at the final tap must compete for best as well.
        if (last_i)
            eye_next = close_run(eye_next);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            hit_cnt <= '0;
            eye     <= '0;
        end else if (clear_i) begin
            hit_cnt <= '0;
            eye     <= '0;
        end else if (observe_i) begin
            if (sync_hit_i && (hit_cnt != THRESH_V))
                hit_cnt <= hit_cnt + 1'b1;
        end else if (eval_i) begin
            eye     <= eye_next;
            hit_cnt <= '0;
        end
    end

    assign best_len_o = eye.best_len;
    assign centre_o   = centre_tap(eye.best_start, eye.best_len);

endmodule

// File: rtl/dphy_delay_calib.sv
// D-PHY IDELAY calibration: sweeps all taps, centres each lane in its widest
// passing run. Optional eye_width_o statistics port under DPHY_CALIB_STATS_EN.
module dphy_delay_calib
    import dphy_calib_pkg::*;
#(
    parameter int unsigned      DATA_LANES    = 2,
    parameter int unsigned      SETTLE_CYCLES = 16,
    parameter int unsigned      WINDOW_CYCLES = 4096,
    parameter int unsigned      PASS_THRESH   = 4,
    parameter logic [TAP_W-1:0] DEFAULT_TAP   = 5'd0
) (
    input  logic                              clk_i,
    input  logic                              rst_i,
    input  logic                              start_i,
    input  logic [DATA_LANES-1:0]             sync_hit_i,
    output logic                              delay_act_o,
    output logic [DATA_LANES-1:0][TAP_W-1:0]  lane_delay_o,
    output logic                              busy_o,
    output logic                              done_o,
    output logic [DATA_LANES-1:0]             lane_fail_o
`ifdef DPHY_CALIB_STATS_EN
    ,
    output logic [DATA_LANES-1:0][RUN_W-1:0]  eye_width_o
`endif
);

    localparam int unsigned CYC_MAX = (SETTLE_CYCLES > WINDOW_CYCLES) ? SETTLE_CYCLES : WINDOW_CYCLES;
    localparam int unsigned CYC_W   = $clog2(CYC_MAX + 1);
    localparam logic [CYC_W-1:0] SETTLE_LAST = CYC_W'(SETTLE_CYCLES - 1);
    localparam logic [CYC_W-1:0] WINDOW_LAST = CYC_W'(WINDOW_CYCLES - 1);
    localparam logic [TAP_W-1:0] TAP_LAST    = TAP_W'(TAP_MAX);

    calib_state_t     state;
    logic [TAP_W-1:0] tap;
    logic [CYC_W-1:0] cyc;

    logic trk_clear;
    logic trk_observe;
    logic trk_eval;
    logic trk_last;

    logic [DATA_LANES-1:0][TAP_W-1:0] centre;
    logic [DATA_LANES-1:0][RUN_W-1:0] best_len;

    assign trk_clear   = (state == ST_IDLE) && start_i;
    assign trk_observe = (state == ST_OBSERVE);
    assign trk_eval    = (state == ST_EVAL);
    assign trk_last    = (tap == TAP_LAST);

    for (genvar i = 0; i < DATA_LANES; i++) begin : g_lane
        dphy_eye_tracker #(
            .PASS_THRESH(PASS_THRESH)
        ) u_tracker (
            .clk_i      (clk_i),
            .rst_i      (rst_i),
            .clear_i    (trk_clear),
            .observe_i  (trk_observe),
            .eval_i     (trk_eval),
            .last_i     (trk_last),
            .sync_hit_i (sync_hit_i[i]),
            .tap_i      (tap),
            .centre_o   (centre[i]),
            .best_len_o (best_len[i])
        );
    end

    // Outputs are registered actions of the current state, so each pulse
    // appears one cycle after the state that requests it.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state        <= ST_IDLE;
            tap          <= '0;
            cyc          <= '0;
            delay_act_o  <= 1'b0;
            lane_delay_o <= {DATA_LANES{DEFAULT_TAP}};
            busy_o       <= 1'b0;
            done_o       <= 1'b0;
            lane_fail_o  <= '0;
`ifdef DPHY_CALIB_STATS_EN
            eye_width_o  <= '0;
`endif
        end else begin
            delay_act_o <= 1'b0;
            done_o      <= 1'b0;
            unique case (state)
                ST_IDLE: begin
                    if (start_i) begin
                        state       <= ST_LOAD;
                        tap         <= '0;
                        cyc         <= '0;
                        lane_fail_o <= '0;
                        busy_o      <= 1'b1;
                    end
                end
                ST_LOAD: begin
                    delay_act_o  <= 1'b1;
                    lane_delay_o <= {DATA_LANES{tap}};
                    cyc          <= '0;
                    state        <= ST_SETTLE;
                end
                ST_SETTLE: begin
                    if (cyc == SETTLE_LAST) begin
                        cyc   <= '0;
                        state <= ST_OBSERVE;
                    end else begin
                        cyc <= cyc + 1'b1;
                    end
                end
                ST_OBSERVE: begin
                    if (cyc == WINDOW_LAST) begin
                        cyc   <= '0;
                        state <= ST_EVAL;
                    end else begin
                        cyc <= cyc + 1'b1;
                    end
                end
                ST_EVAL: begin
                    if (tap == TAP_LAST) begin
                        state <= ST_APPLY;
                    end else begin
                        tap   <= tap + 1'b1;
                        state <= ST_LOAD;
                    end
                end
                ST_APPLY: begin
                    delay_act_o <= 1'b1;
                    for (int unsigned i = 0; i < DATA_LANES; i++) begin
                        if (best_len[i] == '0) begin
                            lane_delay_o[i] <= DEFAULT_TAP;
                            lane_fail_o[i]  <= 1'b1;
                        end else begin
                            lane_delay_o[i] <= centre[i];
                        end
`ifdef DPHY_CALIB_STATS_EN
                        eye_width_o[i] <= best_len[i];
`endif
                    end
                    state <= ST_DONE;
                end
                ST_DONE: begin
                    done_o <= 1'b1;
                    busy_o <= 1'b0;
                    state  <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dphy_delay_calib.sv
// Self-checking bench for dphy_delay_calib: per-tap hit patterns, a reference
// eye search, and a cycle-by-cycle comparison of all outputs.
module tb_dphy_delay_calib;

    localparam int L   = 2;
    localparam int S   = 4;
    localparam int W   = 16;
    localparam int TH  = 4;
    localparam logic [4:0] DEF = 5'd7;
    localparam int P      = 2 + S + W;
    localparam int LAST_J = 32 * P + 2;

    logic                clk_i;
    logic                rst_i;
    logic                start_i;
    logic [L-1:0]        sync_hit_i;
    logic                delay_act_o;
    logic [L-1:0][4:0]   lane_delay_o;
    logic                busy_o;
    logic                done_o;
    logic [L-1:0]        lane_fail_o;
`ifdef DPHY_CALIB_STATS_EN
    logic [L-1:0][5:0]   eye_width_o;
`endif

    dphy_delay_calib #(
        .DATA_LANES   (L),
        .SETTLE_CYCLES(S),
        .WINDOW_CYCLES(W),
        .PASS_THRESH  (TH),
        .DEFAULT_TAP  (DEF)
    ) dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .start_i      (start_i),
        .sync_hit_i   (sync_hit_i),
        .delay_act_o  (delay_act_o),
        .lane_delay_o (lane_delay_o),
        .busy_o       (busy_o),
        .done_o       (done_o),
        .lane_fail_o  (lane_fail_o)
`ifdef DPHY_CALIB_STATS_EN
        ,
        .eye_width_o  (eye_width_o)
`endif
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    int checks = 0;
    int errors = 0;

    // Stimulus pattern: observe-window hit counts per lane/tap.
    int  hits [L][32];
    bit  settle_inj [32];
    bit  eval_inj;
    bit  end_place [L];

    // Expected outputs, compared on every falling edge.
    bit         chk_en;
    logic       exp_act, exp_busy, exp_done;
    logic [4:0] exp_delay [L];
    logic [L-1:0] exp_fail;
    logic [5:0] exp_width [L];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, expv, $time);
        end
    endtask

    always @(negedge clk_i) begin
        if (chk_en) begin
            chk("delay_act", 32'(delay_act_o), 32'(exp_act));
            chk("busy", 32'(busy_o), 32'(exp_busy));
            chk("done", 32'(done_o), 32'(exp_done));
            chk("lane_fail", 32'(lane_fail_o), 32'(exp_fail));
            for (int l = 0; l < L; l++) begin
                chk("lane_delay", 32'(lane_delay_o[l]), 32'(exp_delay[l]));
`ifdef DPHY_CALIB_STATS_EN
                chk("eye_width", 32'(eye_width_o[l]), 32'(exp_width[l]));
`endif
            end
        end
    end

    // Phase of the sweep after the j-th edge following start:
    // 0 idle, 1 load, 2 settle, 3 observe, 4 eval, 5 apply, 6 done.
    function automatic int ph(input int j);
        int o;
        if (j < 0) return 0;
        if (j < 32 * P) begin
            o = j % P;
            if (o == 0) return 1;
            if (o <= S) return 2;
            if (o <= S + W) return 3;
            return 4;
        end
        if (j == 32 * P) return 5;
        if (j == 32 * P + 1) return 6;
        return 0;
    endfunction

    // Longest passing run, earliest on ties.
    task automatic model_lane(input int l, output int bstart, output int blen);
        int cs, cl;
        bstart = 0; blen = 0; cs = 0; cl = 0;
        for (int t = 0; t < 32; t++) begin
            if (hits[l][t] >= TH) begin
                if (cl == 0) cs = t;
                cl++;
                if (cl > blen) begin
                    blen = cl;
                    bstart = cs;
                end
            end else begin
                cl = 0;
            end
        end
    endtask

    task automatic set_reset_exp();
        exp_act = 1'b0; exp_busy = 1'b0; exp_done = 1'b0; exp_fail = '0;
        for (int l = 0; l < L; l++) begin
            exp_delay[l] = DEF;
            exp_width[l] = '0;
        end
    endtask

    task automatic idle_cycles(input int n);
        repeat (n) begin
            @(posedge clk_i); #1;
            exp_act = 1'b0;
            exp_done = 1'b0;
        end
    endtask

    task automatic clear_pattern();
        for (int l = 0; l < L; l++) begin
            for (int t = 0; t < 32; t++) hits[l][t] = 0;
            end_place[l] = 1'b0;
        end
        for (int t = 0; t < 32; t++) settle_inj[t] = 1'b0;
        eval_inj = 1'b0;
    endtask

    task automatic random_pattern();
        int n, st, ln;
        clear_pattern();
        for (int l = 0; l < L; l++) begin
            for (int t = 0; t < 32; t++) hits[l][t] = int'($urandom_range(0, TH - 1));
            n = int'($urandom_range(0, 3));
            for (int k = 0; k < n; k++) begin
                st = int'($urandom_range(0, 31));
                ln = int'($urandom_range(1, 12));
                for (int t = st; t < st + ln && t < 32; t++) hits[l][t] = int'($urandom_range(TH, W));
            end
            end_place[l] = 1'($urandom_range(0, 1));
        end
        for (int t = 0; t < 32; t++) settle_inj[t] = 1'($urandom_range(0, 1));
        eval_inj = 1'($urandom_range(0, 1));
    endtask

    // Runs one calibration; abort_j >= 0 asserts reset after that edge.
    task automatic run_cal(input int abort_j, input int restart_j, output int done_j, output int acts);
        int bs, bl, t, o, m;
        logic [4:0] res_delay [L];
        logic [L-1:0] res_fail;
        logic [5:0] res_len [L];
        for (int l = 0; l < L; l++) begin
            model_lane(l, bs, bl);
            res_len[l]   = 6'(bl);
            res_fail[l]  = (bl == 0);
            res_delay[l] = (bl == 0) ? DEF : 5'(bs + (bl - 1) / 2);
        end
        done_j = -1;
        acts = 0;
        @(posedge clk_i); #1;
        exp_act = 1'b0; exp_done = 1'b0;
        start_i = 1'b1;
        for (int j = 0; j <= LAST_J; j++) begin
            @(posedge clk_i); #1;
            start_i = (j == restart_j);
            if (j == abort_j) begin
                rst_i = 1'b1;
                start_i = 1'b0;
                sync_hit_i = '0;
                set_reset_exp();
                idle_cycles(3);
                rst_i = 1'b0;
                idle_cycles(4);
                return;
            end
            if (j == 0) exp_fail = '0;
            exp_busy = (j <= 32 * P + 1);
            exp_done = (j == LAST_J);
            exp_act  = (ph(j - 1) == 1) || (ph(j - 1) == 5);
            if (ph(j - 1) == 1) begin
                for (int l = 0; l < L; l++) exp_delay[l] = 5'((j - 1) / P);
            end
            if (ph(j - 1) == 5) begin
                for (int l = 0; l < L; l++) begin
                    exp_delay[l] = res_delay[l];
                    exp_width[l] = res_len[l];
                end
                exp_fail = res_fail;
            end
            if (delay_act_o === 1'b1) acts++;
            if (done_o === 1'b1 && done_j < 0) done_j = j;
            sync_hit_i = '0;
            t = j / P;
            o = j % P;
            case (ph(j))
                2: if (settle_inj[t]) sync_hit_i = '1;
                3: begin
                    m = o - S - 1;
                    for (int l = 0; l < L; l++)
                        sync_hit_i[l] = end_place[l] ? (m >= W - hits[l][t]) : (m < hits[l][t]);
                end
                4: if (eval_inj) sync_hit_i = '1;
                default: ;
            endcase
        end
        sync_hit_i = '0;
        start_i = 1'b0;
        idle_cycles(3);
    endtask

    int dj, na;

    initial begin
        rst_i = 1'b1;
        start_i = 1'b0;
        sync_hit_i = '0;
        chk_en = 1'b0;
        set_reset_exp();
        @(posedge clk_i); #1;
        chk_en = 1'b1;
        idle_cycles(2);
        rst_i = 1'b0;
        idle_cycles(2);
        chk("reset_delay0", 32'(lane_delay_o[0]), 32'd7);
        chk("reset_busy", 32'(busy_o), 32'd0);

        // Lane 0 passes 8..15 at exactly threshold, lane 1 passes 20..29.
        clear_pattern();
        for (int t = 8; t <= 15; t++) hits[0][t] = TH;
        hits[0][16] = TH - 1;
        for (int t = 20; t <= 29; t++) hits[1][t] = W;
        end_place[0] = 1'b1;
        eval_inj = 1'b1;
        run_cal(-1, 100, dj, na);
        chk("t1_lane0", 32'(lane_delay_o[0]), 32'd11);
        chk("t1_lane1", 32'(lane_delay_o[1]), 32'd24);
        chk("t1_fail", 32'(lane_fail_o), 32'd0);
        chk("t1_acts", 32'(na), 32'd33);
        chk("t1_latency", 32'(dj + 1), 32'd707);

        // Equal runs on lane 0, full sweep on lane 1.
        clear_pattern();
        for (int t = 2; t <= 4; t++) hits[0][t] = W;
        for (int t = 10; t <= 12; t++) hits[0][t] = W;
        for (int t = 0; t < 32; t++) hits[1][t] = TH;
        run_cal(-1, -1, dj, na);
        chk("t2_lane0", 32'(lane_delay_o[0]), 32'd3);
        chk("t2_lane1", 32'(lane_delay_o[1]), 32'd15);
`ifdef DPHY_CALIB_STATS_EN
        chk("t2_width0", 32'(eye_width_o[0]), 32'd3);
        chk("t2_width1", 32'(eye_width_o[1]), 32'd32);
`endif

        // No lane reaches threshold; a dropped eval hit would tip lane 0 over.
        clear_pattern();
        for (int t = 0; t < 32; t++) hits[0][t] = TH - 1;
        eval_inj = 1'b1;
        run_cal(-1, -1, dj, na);
        chk("t3_lane0", 32'(lane_delay_o[0]), 32'd7);
        chk("t3_lane1", 32'(lane_delay_o[1]), 32'd7);
        chk("t3_fail", 32'(lane_fail_o), 32'd3);

        // Settle-time hits must not count.
        clear_pattern();
        for (int t = 28; t <= 31; t++) hits[0][t] = TH;
        for (int t = 0; t <= 27; t++) settle_inj[t] = 1'b1;
        run_cal(-1, -1, dj, na);
        chk("t4_lane0", 32'(lane_delay_o[0]), 32'd29);
        chk("t4_fail", 32'(lane_fail_o), 32'd2);

        // Reset in the middle of tap 17, then a clean restart.
        random_pattern();
        run_cal(17 * P + 7, -1, dj, na);
        chk("t5_abort_delay1", 32'(lane_delay_o[1]), 32'd7);
        chk("t5_abort_fail", 32'(lane_fail_o), 32'd0);
        random_pattern();
        run_cal(-1, -1, dj, na);
        chk("t5_acts", 32'(na), 32'd33);

        for (int r = 0; r < 4; r++) begin
            random_pattern();
            run_cal(-1, int'($urandom_range(1, 32 * P)), dj, na);
            chk("rand_latency", 32'(dj + 1), 32'd707);
        end

        chk_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
